// File: rtl/processor.sv
// processor: registered LEGv8-subset instruction decoder / control unit.
// Classifies each instruction into a format type and produces datapath
// control flags, a 4-bit ALU operation code and register-file addresses,
// all registered with one cycle of latency.
module processor #(
  parameter logic [2:0] INVALID_OP = 3'd7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  output logic        regWriteFlag,
  output logic [2:0]  opType,
  output logic        memWriteFlag,
  output logic        memReadFlag,
  output logic [3:0]  aluControlCode,
  output logic        branchFlag,
  output logic        unconditionalBranchFlag,
  output logic        aluSRC,
  output logic [4:0]  readRegister1,
  output logic [4:0]  readRegister2,
  output logic [4:0]  writeRegister,
  output logic        memToReg
);

  localparam logic [2:0] OP_R      = 3'd0;
  localparam logic [2:0] OP_I      = 3'd1;
  localparam logic [2:0] OP_DLOAD  = 3'd2;
  localparam logic [2:0] OP_B      = 3'd3;
  localparam logic [2:0] OP_CB     = 3'd4;
  localparam logic [2:0] OP_IM     = 3'd5;
  localparam logic [2:0] OP_DSTORE = 3'd6;

  localparam logic [3:0] ALU_NONE = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_AND  = 4'd6;
  localparam logic [3:0] ALU_PASS = 4'd7;
  localparam logic [3:0] ALU_XOR  = 4'd9;
  localparam logic [3:0] ALU_SUB  = 4'd10;
  localparam logic [3:0] ALU_MOV  = 4'd13;

  logic [2:0] op_next;
  logic [3:0] alu_next;
  logic [3:0] alu_rtype;
  logic       reg_write_next;
  logic       mem_write_next;
  logic       mem_read_next;
  logic       branch_next;
  logic       ubranch_next;
  logic       alu_src_next;
  logic       mem_to_reg_next;
  logic [4:0] read_reg2_next;

  // Priority classification of the instruction format; first match wins.
  always_comb begin
    op_next = INVALID_OP;
    if (instruction[26] && instruction[29])      op_next = OP_CB;
    else if (instruction[26])                    op_next = OP_B;
    else if (instruction[28] && instruction[22]) op_next = OP_DLOAD;
    else if (instruction[28] && instruction[27]) op_next = OP_DSTORE;
    else if (instruction[28] && instruction[23]) op_next = OP_IM;
    else if (instruction[28])                    op_next = OP_I;
    else if (instruction[27])                    op_next = OP_R;
  end

  // ALU code shared by R and I formats: i24 picks arithmetic vs logical.
  always_comb begin
    alu_rtype = ALU_AND;
    if (instruction[24]) begin
      alu_rtype = instruction[30] ? ALU_SUB : ALU_ADD;
    end else begin
      case (instruction[30:29])
        2'b00:   alu_rtype = ALU_AND;
        2'b01:   alu_rtype = ALU_OR;
        2'b10:   alu_rtype = ALU_XOR;
        default: alu_rtype = ALU_AND;
      endcase
    end
  end

  // Control flags, ALU code and second read address derived from the type.
  always_comb begin
    reg_write_next  = 1'b0;
    mem_write_next  = 1'b0;
    mem_read_next   = 1'b0;
    branch_next     = 1'b0;
    ubranch_next    = 1'b0;
    alu_src_next    = 1'b0;
    mem_to_reg_next = 1'b0;
    alu_next        = ALU_NONE;
    read_reg2_next  = instruction[20:16];
    case (op_next)
      OP_R: begin
        reg_write_next = 1'b1;
        alu_next       = alu_rtype;
      end
      OP_I: begin
        reg_write_next = 1'b1;
        alu_src_next   = 1'b1;
        alu_next       = alu_rtype;
      end
      OP_DLOAD: begin
        reg_write_next  = 1'b1;
        alu_src_next    = 1'b1;
        mem_read_next   = 1'b1;
        mem_to_reg_next = 1'b1;
        alu_next        = ALU_ADD;
      end
      OP_DSTORE: begin
        alu_src_next   = 1'b1;
        mem_write_next = 1'b1;
        alu_next       = ALU_ADD;
        read_reg2_next = instruction[4:0];
      end
      OP_CB: begin
        branch_next    = 1'b1;
        alu_next       = ALU_PASS;
        read_reg2_next = instruction[4:0];
      end
      OP_B: begin
        ubranch_next = 1'b1;
      end
      OP_IM: begin
        reg_write_next = 1'b1;
        alu_src_next   = 1'b1;
        alu_next       = ALU_MOV;
      end
      default: begin
      end
    endcase
  end

  // Output register: loads the decode each edge, async reset to idle values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opType                  <= INVALID_OP;
      regWriteFlag            <= 1'b0;
      memWriteFlag            <= 1'b0;
      memReadFlag             <= 1'b0;
      branchFlag              <= 1'b0;
      unconditionalBranchFlag <= 1'b0;
      aluSRC                  <= 1'b0;
      memToReg                <= 1'b0;
      aluControlCode          <= ALU_NONE;
      readRegister1           <= 5'd0;
      readRegister2           <= 5'd0;
      writeRegister           <= 5'd0;
    end else begin
      opType                  <= op_next;
      regWriteFlag            <= reg_write_next;
      memWriteFlag            <= mem_write_next;
      memReadFlag             <= mem_read_next;
      branchFlag              <= branch_next;
      unconditionalBranchFlag <= ubranch_next;
      aluSRC                  <= alu_src_next;
      memToReg                <= mem_to_reg_next;
      aluControlCode          <= alu_next;
      readRegister1           <= instruction[9:5];
      readRegister2           <= read_reg2_next;
      writeRegister           <= instruction[4:0];
    end
  end

endmodule

// File: tb/tb_processor.sv
// tb_processor: directed vectors with hand-computed decode results.
module tb_processor;

  logic        clk;
  logic        reset;
  logic [31:0] instruction;
  logic        regWriteFlag;
  logic [2:0]  opType;
  logic        memWriteFlag;
  logic        memReadFlag;
  logic [3:0]  aluControlCode;
  logic        branchFlag;
  logic        unconditionalBranchFlag;
  logic        aluSRC;
  logic [4:0]  readRegister1;
  logic [4:0]  readRegister2;
  logic [4:0]  writeRegister;
  logic        memToReg;

  int checks;
  int errors;

  processor dut (
    .clk                     (clk),
    .reset                   (reset),
    .instruction             (instruction),
    .regWriteFlag            (regWriteFlag),
    .opType                  (opType),
    .memWriteFlag            (memWriteFlag),
    .memReadFlag             (memReadFlag),
    .aluControlCode          (aluControlCode),
    .branchFlag              (branchFlag),
    .unconditionalBranchFlag (unconditionalBranchFlag),
    .aluSRC                  (aluSRC),
    .readRegister1           (readRegister1),
    .readRegister2           (readRegister2),
    .writeRegister           (writeRegister),
    .memToReg                (memToReg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flags packed as {regWrite, aluSRC, memRead, memToReg, memWrite, branch, uncond}.
  typedef struct {
    string       tag;
    logic [31:0] instr;
    logic [2:0]  op;
    logic [3:0]  alu;
    logic [6:0]  flags;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic [4:0]  wr;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [2:0] op, input logic [3:0] alu,
                               input logic [6:0] flags, input logic [4:0] rr1,
                               input logic [4:0] rr2, input logic [4:0] wr);
    logic [6:0] got_flags;
    got_flags = {regWriteFlag, aluSRC, memReadFlag, memToReg, memWriteFlag,
                 branchFlag, unconditionalBranchFlag};
    check({tag, ".opType"}, 32'(opType), 32'(op));
    check({tag, ".alu"},    32'(aluControlCode), 32'(alu));
    check({tag, ".flags"},  32'(got_flags), 32'(flags));
    check({tag, ".rr1"},    32'(readRegister1), 32'(rr1));
    check({tag, ".rr2"},    32'(readRegister2), 32'(rr2));
    check({tag, ".wr"},     32'(writeRegister), 32'(wr));
  endtask

  task automatic add(input string tag, input logic [31:0] instr, input logic [2:0] op,
                     input logic [3:0] alu, input logic [6:0] flags,
                     input logic [4:0] rr1, input logic [4:0] rr2, input logic [4:0] wr);
    vec_t v;
    v.tag = tag; v.instr = instr; v.op = op; v.alu = alu; v.flags = flags;
    v.rr1 = rr1; v.rr2 = rr2; v.wr = wr;
    vecs.push_back(v);
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    instruction = v.instr;
    @(posedge clk);
    #1;
    check_outputs(v.tag, v.op, v.alu, v.flags, v.rr1, v.rr2, v.wr);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b0;
    instruction = 32'h0000_0000;

    //   tag       instr         op  alu  flags       rr1 rr2 wr
    add("load",    32'h10400000, 2,  2,  7'b1111000, 0,  0,  0);
    add("cbz",     32'h24000000, 4,  7,  7'b0000010, 0,  0,  0);
    add("b",       32'h04000000, 3,  0,  7'b0000001, 0,  0,  0);
    add("store",   32'h18000000, 6,  2,  7'b0100100, 0,  0,  0);
    add("r_and",   32'h08000000, 0,  6,  7'b1000000, 0,  0,  0);
    add("i_and",   32'h10000000, 1,  6,  7'b1100000, 0,  0,  0);
    add("movz",    32'h10800000, 5,  13, 7'b1100000, 0,  0,  0);
    add("add",     32'h8B150289, 0,  2,  7'b1000000, 20, 21, 9);
    add("addi",    32'h910006D6, 1,  2,  7'b1100000, 22, 0,  22);
    add("r_or",    32'h28000000, 0,  4,  7'b1000000, 0,  0,  0);
    add("r_xor",   32'h48000000, 0,  9,  7'b1000000, 0,  0,  0);
    add("r_and11", 32'h68000000, 0,  6,  7'b1000000, 0,  0,  0);
    add("i_or",    32'h30000000, 1,  4,  7'b1100000, 0,  0,  0);
    add("subi",    32'hD1000000, 1,  10, 7'b1100000, 0,  0,  0);
    add("store_rt",32'h180A0123, 6,  2,  7'b0100100, 9,  3,  3);
    add("cb_prio", 32'hB4000045, 4,  7,  7'b0000010, 2,  5,  5);
    add("invalid", 32'h000003E5, 7,  0,  7'b0000000, 31, 0,  5);
    add("sub",     32'hCB150289, 0,  10, 7'b1000000, 20, 21, 9);

    // Async reset between edges, before any decode.
    #2;
    reset = 1'b1;
    #1;
    check_outputs("reset_init", 3'd7, 4'd0, 7'b0, 5'd0, 5'd0, 5'd0);
    @(posedge clk);
    #1;
    check_outputs("reset_held", 3'd7, 4'd0, 7'b0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Mid-cycle reset after SUB has been decoded: must clear before next edge.
    #2;
    reset = 1'b1;
    #1;
    check_outputs("reset_mid", 3'd7, 4'd0, 7'b0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    reset = 1'b0;

    // Decoding resumes on the first edge after release.
    run_vec(vecs[7]);
    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/processor.md
Name: processor

Overview:
- Registered instruction decoder / control unit for the LEGv8-subset CPU datapath.
- Each cycle it classifies a 32-bit instruction into a format type (opType).
- From that type it produces datapath control flags, a 4-bit ALU operation code, and register-file addresses.
- It sits between instruction fetch and the register file / ALU / data memory.

Parameters:
- INVALID_OP, 3'd7, opType value for unrecognised instructions and for reset.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- instruction  input  32  instruction word to decode
- regWriteFlag  output  1  register-file write enable
- opType  output  3  format: 0=R, 1=I, 2=D-load, 3=B, 4=CB, 5=IM(MOV), 6=D-store, 7=invalid
- memWriteFlag  output  1  data-memory write enable
- memReadFlag  output  1  data-memory read enable
- aluControlCode  output  4  ALU operation: 2 ADD, 10 SUB, 6 AND, 4 OR, 9 XOR, 7 pass-B (CBZ), 13 MOV, 0 none
- branchFlag  output  1  conditional branch
- unconditionalBranchFlag  output  1  unconditional branch
- aluSRC  output  1  ALU operand B select: 1=immediate, 0=register
- readRegister1  output  5  register-file read address 1
- readRegister2  output  5  register-file read address 2
- writeRegister  output  5  register-file write address
- memToReg  output  1  write-back select: 1=memory data, 0=ALU result

Behaviour:
- All outputs are registered.
- On each rising clk, the outputs load the decode of the instruction present at that edge. Latency is exactly 1 cycle; there is no handshake.
- Reset is asynchronous: while reset=1, all flags are 0, all register addresses are 0, aluControlCode=0, and opType=7. Decoding resumes at the first rising clk after reset deasserts.
- Type classification uses priority, first match wins (i[n] = instruction bit n):
  1. i26 & i29 -> CB (4)
  2. i26 -> B (3)
  3. i28 & i22 -> D-load (2)
  4. i28 & i27 -> D-store (6)
  5. i28 & i23 -> IM (5)
  6. i28 -> I (1)
  7. i27 -> R (0)
  8. otherwise -> invalid (7)
- Flags per type; any flag not listed is 0:
  - R: regWriteFlag.
  - I: regWriteFlag, aluSRC.
  - D-load: regWriteFlag, aluSRC, memReadFlag, memToReg.
  - D-store: aluSRC, memWriteFlag.
  - CB: branchFlag.
  - B: unconditionalBranchFlag.
  - IM: regWriteFlag, aluSRC.
  - Invalid: all flags 0.
- aluControlCode for R and I types:
  - If i24=1 (arithmetic): i30=0 -> 2 (ADD), i30=1 -> 10 (SUB).
  - If i24=0 (logical), by i30:i29: 00 -> 6 (AND), 01 -> 4 (OR), 10 -> 9 (XOR), 11 -> 6 (AND).
- aluControlCode for other types: D-load and D-store -> 2; CB -> 7; IM -> 13; B and invalid -> 0.
- readRegister1 = i[9:5] for every type, including invalid.
- readRegister2 = i[4:0] (Rt) for D-store and CB; i[20:16] (Rm) for all other types.
- writeRegister = i[4:0] for every type.
- An X/Z instruction after reset need not produce defined outputs; a known instruction decodes correctly on the next edge.
- Back-to-back instructions on consecutive edges are each decoded independently. Nothing is held from the previous cycle.
- Reset asserted mid-stream forces reset values immediately, without waiting for clk.

Test Plan:
- Reset: assert reset between edges -> outputs immediately opType=7, all flags 0, aluControlCode=0, all addresses 0.
- Instruction 0x10400000 (load) -> after 1 edge: opType=2, regWriteFlag=1, aluSRC=1, memReadFlag=1, memToReg=1, memWriteFlag=0, aluControlCode=2.
- Instruction 0x24000000, then 0x04000000, then 0x18000000:
  - 0x24000000 -> opType=4, branchFlag=1, aluControlCode=7, readRegister2=0.
  - 0x04000000 -> opType=3, unconditionalBranchFlag=1, aluControlCode=0.
  - 0x18000000 -> opType=6, memWriteFlag=1, aluSRC=1, regWriteFlag=0.
- Instruction 0x08000000, then 0x10000000, then 0x10800000:
  - 0x08000000 -> opType=0, regWriteFlag=1, aluSRC=0, aluControlCode=6.
  - 0x10000000 -> opType=1, aluSRC=1, aluControlCode=6.
  - 0x10800000 -> opType=5, aluControlCode=13.
- Instruction 0x8B150289 (ADD X9,X20,X21) -> opType=0, aluControlCode=2, readRegister1=20, readRegister2=21, writeRegister=9, regWriteFlag=1.
- Instruction 0x910006D6 (ADDI X22,X22,#1) -> opType=1, aluControlCode=2, readRegister1=22, writeRegister=22, aluSRC=1.
- Instruction 0xCB150289 (SUB) -> aluControlCode=10. Then assert reset asynchronously mid-cycle -> outputs return to reset values before the next edge.
